// File: rtl/btn_alu_op_select.sv
// Push-button ALU operation selector: three synchronised and debounced buttons
// pick an entry of a fixed 8-entry op table, either directly or by stepping.
module btn_alu_op_select #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       btnl,
    input  logic       btnc,
    input  logic       btnr,
    output logic [3:0] alu_op,
    output logic [2:0] op_idx,
    output logic       op_changed
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [3:0] op_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    op_lut = 4'b0010;
            3'd1:    op_lut = 4'b0110;
            3'd2:    op_lut = 4'b0000;
            3'd3:    op_lut = 4'b0001;
            3'd4:    op_lut = 4'b1101;
            3'd5:    op_lut = 4'b0111;
            3'd6:    op_lut = 4'b1001;
            default: op_lut = 4'b1010;
        endcase
    endfunction

    // Bit order everywhere is {l, c, r}, which is also the table index order.
    logic [2:0]             pads;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [CNT_W-1:0]       cnt_q  [3];
    logic [2:0]             stable_q;
    logic [2:0]             prev_q;
    logic [2:0]             rise;
    logic [2:0]             next_idx;
    logic [3:0]             next_op;

    assign pads = {btnl, btnc, btnr};
    assign rise = stable_q & ~prev_q;

    always_comb begin
        next_idx = op_idx;
        if (!mode) begin
            next_idx = stable_q;
        end else if (rise[1]) begin
            next_idx = 3'd0;
        end else if (rise[2] && rise[0]) begin
            next_idx = op_idx;
        end else if (rise[0]) begin
            next_idx = op_idx + 3'd1;
        end else if (rise[2]) begin
            next_idx = op_idx - 3'd1;
        end
        next_op = op_lut(next_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                sync_q[b] <= '0;
                cnt_q[b]  <= '0;
            end
            stable_q   <= '0;
            prev_q     <= '0;
            op_idx     <= 3'd0;
            alu_op     <= 4'b0010;
            op_changed <= 1'b0;
        end else begin
            prev_q <= stable_q;
            for (int b = 0; b < 3; b++) begin
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], pads[b]};
                // Any return to the stable level restarts qualification.
                if (sync_q[b][SYNC_STAGES-1] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_MAX) begin
                    stable_q[b] <= sync_q[b][SYNC_STAGES-1];
                    cnt_q[b]    <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end
            end
            op_idx     <= next_idx;
            alu_op     <= next_op;
            op_changed <= (next_op != alu_op);
        end
    end

endmodule

// File: tb/tb_btn_alu_op_select.sv
// Bench for btn_alu_op_select with SYNC_STAGES=2, DEBOUNCE_CYCLES=4: directed
// vector table, hand-written latency/reset/mode sequences, then random stimulus.
module tb_btn_alu_op_select;

    localparam int S = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       btnl = 1'b0;
    logic       btnc = 1'b0;
    logic       btnr = 1'b0;
    logic [3:0] alu_op;
    logic [2:0] op_idx;
    logic       op_changed;

    btn_alu_op_select #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .btnl(btnl), .btnc(btnc), .btnr(btnr),
        .alu_op(alu_op), .op_idx(op_idx), .op_changed(op_changed)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: pads seen by the debouncer are simply the pads from S
    // edges ago; a level is accepted after D consecutive differing samples.
    logic [3:0] op_tab [8];
    logic       m_dq [3][$];
    int         m_run [3];
    logic [2:0] m_st, m_prv, m_idx;
    logic [3:0] m_alu;
    logic       m_chg;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [2:0] pads, rise, nidx;
        logic [3:0] nalu;
        logic       seen;
        pads = {btnl, btnc, btnr};
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                m_dq[b].delete();
                for (int k = 0; k < S; k++) m_dq[b].push_back(1'b0);
                m_run[b] = 0;
            end
            m_st = 3'd0; m_prv = 3'd0; m_idx = 3'd0; m_alu = 4'b0010; m_chg = 1'b0;
        end else begin
            rise = m_st & ~m_prv;
            if (!mode)                  nidx = m_st;
            else if (rise[1])           nidx = 3'd0;
            else if (rise[2] && rise[0]) nidx = m_idx;
            else if (rise[0])           nidx = 3'((int'(m_idx) + 1) % 8);
            else if (rise[2])           nidx = 3'((int'(m_idx) + 7) % 8);
            else                        nidx = m_idx;
            nalu  = op_tab[nidx];
            m_chg = (nalu != m_alu);
            m_idx = nidx;
            m_alu = nalu;
            m_prv = m_st;
            for (int b = 0; b < 3; b++) begin
                seen = m_dq[b].pop_front();
                m_dq[b].push_back(pads[b]);
                if (seen != m_st[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_st[b]  = seen;
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    endtask

    // driver: one clock with the current inputs, scoreboard compare after
    task automatic tick();
        logic [7:0] e;
        model_step();
        exp_q.push_back({m_alu, m_idx, m_chg});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("model", {alu_op, op_idx, op_changed}, e);
    endtask

    task automatic set_in(input logic m, input logic [2:0] p);
        mode = m;
        {btnl, btnc, btnr} = p;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       mode;
        logic [2:0] pads;
        int         cycles;
        logic [3:0] exp_op;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic m, input logic [2:0] p, input int c,
                                input logic [3:0] o, input logic [2:0] i);
        vec_t v;
        v.mode = m; v.pads = p; v.cycles = c; v.exp_op = o; v.exp_idx = i;
        return v;
    endfunction

    initial begin
        op_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101, 4'b0111, 4'b1001, 4'b1010};

        // DIRECT basics and glitch rejection
        vecs.push_back(mk(0, 3'b000, 3,  4'b0010, 3'd0));
        vecs.push_back(mk(0, 3'b100, 10, 4'b1101, 3'd4));
        vecs.push_back(mk(0, 3'b000, 10, 4'b0010, 3'd0));
        vecs.push_back(mk(0, 3'b001, 3,  4'b0010, 3'd0));
        vecs.push_back(mk(0, 3'b000, 10, 4'b0010, 3'd0));
        // STEP: four btnr presses, btnc clear, btnl wraps to 7
        vecs.push_back(mk(1, 3'b001, 10, 4'b0110, 3'd1));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0110, 3'd1));
        vecs.push_back(mk(1, 3'b001, 10, 4'b0000, 3'd2));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0000, 3'd2));
        vecs.push_back(mk(1, 3'b001, 10, 4'b0001, 3'd3));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0001, 3'd3));
        vecs.push_back(mk(1, 3'b001, 10, 4'b1101, 3'd4));
        vecs.push_back(mk(1, 3'b000, 10, 4'b1101, 3'd4));
        vecs.push_back(mk(1, 3'b010, 10, 4'b0010, 3'd0));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0010, 3'd0));
        vecs.push_back(mk(1, 3'b100, 10, 4'b1010, 3'd7));
        vecs.push_back(mk(1, 3'b000, 10, 4'b1010, 3'd7));
        // reach idx 5 via DIRECT, then all three together, then l+r only
        vecs.push_back(mk(0, 3'b101, 10, 4'b0111, 3'd5));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0111, 3'd5));
        vecs.push_back(mk(1, 3'b111, 10, 4'b0010, 3'd0));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0010, 3'd0));
        vecs.push_back(mk(0, 3'b101, 10, 4'b0111, 3'd5));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0111, 3'd5));
        vecs.push_back(mk(1, 3'b101, 10, 4'b0111, 3'd5));
        vecs.push_back(mk(1, 3'b000, 10, 4'b0111, 3'd5));
        // DIRECT code 6, STEP press r, then back to DIRECT (finished below)
        vecs.push_back(mk(0, 3'b110, 10, 4'b1001, 3'd6));
        vecs.push_back(mk(1, 3'b110, 10, 4'b1001, 3'd6));
        vecs.push_back(mk(1, 3'b111, 10, 4'b1010, 3'd7));
        vecs.push_back(mk(1, 3'b110, 10, 4'b1010, 3'd7));

        // reset state and exact DIRECT latency / single-cycle pulse
        set_in(0, 3'b000);
        do_reset();
        check("reset_out", {alu_op, op_idx, op_changed}, {4'b0010, 3'd0, 1'b0});
        set_in(0, 3'b100);
        for (int e = 1; e <= S + D; e++) begin
            tick();
            check("latency_hold", {4'b0, alu_op}, 8'h02);
        end
        tick();
        check("latency_edge7", {alu_op, op_idx, op_changed}, {4'b1101, 3'd4, 1'b1});
        tick();
        check("pulse_one_cycle", {7'd0, op_changed}, 8'd0);

        // table vectors
        set_in(0, 3'b000);
        do_reset();
        foreach (vecs[i]) begin
            set_in(vecs[i].mode, vecs[i].pads);
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d", i), {1'b0, alu_op, op_idx}, {1'b0, vecs[i].exp_op, vecs[i].exp_idx});
        end
        set_in(0, 3'b110);
        tick();
        check("step_to_direct", {alu_op, op_idx, op_changed}, {4'b1001, 3'd6, 1'b1});

        // reset in the middle of a debounce with btnr held through it
        set_in(1, 3'b000);
        do_reset();
        set_in(1, 3'b001);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_debounce", {alu_op, op_idx, op_changed}, {4'b0010, 3'd0, 1'b0});
        for (int e = 1; e <= S + D; e++) begin
            tick();
            check("requalify_hold", {5'd0, op_idx}, 8'd0);
        end
        tick();
        check("requalify_step", {alu_op, op_idx, op_changed}, {4'b0110, 3'd1, 1'b1});

        // random segments against the model
        set_in(0, 3'b000);
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 15) == 0);
            tick();
            rst = 1'b0;
            repeat ($urandom_range(0, 11)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
